nem_ohmux_seq_invd0: RTL and testbench

NEM_OHMUX_SEQ_INVD0 -- requirements
Module: nem_ohmux_seq_invd0

---
 rtl/nem_ohmux_seq_invd0.sv | 125 ++++++++++++
 tb/tb_nem_ohmux_seq_invd0.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nem_ohmux_seq_invd0.sv
// nem_ohmux_seq_invd0: break-before-make relay one-hot mux with inverted output
module nem_ohmux_seq_invd0 #(
    parameter int N_IN    = 4,
    parameter int WIDTH   = 1,
    parameter int T_BREAK = 2,
    parameter int T_MAKE  = 3
) (
    input  logic                    CP,
    input  logic                    RST,
    input  logic [N_IN*WIDTH-1:0]   I,
    input  logic                    REQ_VLD,
    input  logic [$clog2(N_IN)-1:0] REQ_IDX,
    input  logic                    REQ_OFF,
    output logic                    REQ_RDY,
    output logic [N_IN-1:0]         S,
    output logic [WIDTH-1:0]        ZN,
    output logic                    LOCKED,
    output logic                    DONE,
    output logic                    ERR
);
    localparam int IW = $clog2(N_IN);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BREAK = 2'd1;
    localparam logic [1:0] ST_MAKE  = 2'd2;
    localparam logic [IW:0] N_LIM = N_IN[IW:0];
    localparam logic [3:0] CNT_B = 4'(T_BREAK - 1);
    localparam logic [3:0] CNT_M = 4'(T_MAKE - 1);
    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   tgt_q, tgt_d;
    logic            off_q, off_d;
    logic [N_IN-1:0] s_q, s_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [WIDTH-1:0] mux_or;

    // An out-of-range index is folded into an all-open request
    wire             req_bad = !REQ_OFF && ({1'b0, REQ_IDX} >= N_LIM);
    wire             req_off = REQ_OFF || req_bad;
    wire [N_IN-1:0]  req_hot = ONE << REQ_IDX;
    wire             req_nop = req_off ? (s_q == '0) : (s_q == req_hot);

    assign REQ_RDY = (state_q == ST_IDLE) && !RST;
    assign LOCKED  = (state_q == ST_IDLE) && (s_q != '0);
    assign S       = s_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign ZN      = ~mux_or;

    // Wired-OR of the closed relay's input; nothing closed reads as zero
    always_comb begin
        mux_or = '0;
        for (int i = 0; i < N_IN; i++)
            mux_or = mux_or | ({WIDTH{s_q[i]}} & I[i*WIDTH +: WIDTH]);
    end

    // Sequencer: every change of closed relay passes through all-open
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        off_d   = off_q;
        s_d     = s_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (REQ_VLD) begin
                tgt_d = REQ_IDX;
                off_d = req_off;
                err_d = err_q || req_bad;
                if (req_nop) begin
                    done_d = 1'b1;
                end else if (s_q != '0) begin
                    s_d     = '0;
                    state_d = ST_BREAK;
                    cnt_d   = CNT_B;
                end else begin
                    s_d     = req_hot;
                    state_d = ST_MAKE;
                    cnt_d   = CNT_M;
                end
            end
            ST_BREAK: if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else if (off_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                s_d     = ONE << tgt_q;
                state_d = ST_MAKE;
                cnt_d   = CNT_M;
            end
            ST_MAKE: if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops every relay and aborts any transition
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            off_q   <= 1'b0;
            s_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            off_q   <= off_d;
            s_q     <= s_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_nem_ohmux_seq_invd0.sv
// tb_nem_ohmux_seq_invd0: scoreboard bench for the sequenced relay mux
module tb_nem_ohmux_seq_invd0;
    typedef struct {
        logic [3:0] s;
        logic [1:0] zn;
        logic       lk;
        logic       er;
        int         cyc;
    } exp_t;

    logic       CP = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] I = 8'b01_10_11_00;
    logic       REQ_VLD = 1'b0;
    logic [1:0] REQ_IDX = '0;
    logic       REQ_OFF = 1'b0;
    logic       REQ_RDY, LOCKED, DONE, ERR;
    logic [3:0] S;
    logic [1:0] ZN;

    logic       RST3 = 1'b1;
    logic [5:0] I3 = 6'b00_01_11;
    logic       VLD3 = 1'b0;
    logic [1:0] IDX3 = '0;
    logic       OFF3 = 1'b0;
    logic       RDY3, LOCKED3, DONE3, ERR3;
    logic [2:0] S3;
    logic [1:0] ZN3;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    nem_ohmux_seq_invd0 #(.N_IN(4), .WIDTH(2), .T_BREAK(2), .T_MAKE(3)) dut (
        .CP(CP), .RST(RST), .I(I), .REQ_VLD(REQ_VLD), .REQ_IDX(REQ_IDX),
        .REQ_OFF(REQ_OFF), .REQ_RDY(REQ_RDY), .S(S), .ZN(ZN),
        .LOCKED(LOCKED), .DONE(DONE), .ERR(ERR)
    );

    nem_ohmux_seq_invd0 #(.N_IN(3), .WIDTH(2), .T_BREAK(2), .T_MAKE(3)) dut3 (
        .CP(CP), .RST(RST3), .I(I3), .REQ_VLD(VLD3), .REQ_IDX(IDX3),
        .REQ_OFF(OFF3), .REQ_RDY(RDY3), .S(S3), .ZN(ZN3),
        .LOCKED(LOCKED3), .DONE(DONE3), .ERR(ERR3)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per DONE pulse and checks S never has two bits set
    always @(negedge CP) begin
        chk("s_onehot0", 32'($onehot0(S)), 32'd1);
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(DONE), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_s", S, mon_e.s);
                chk("done_zn", ZN, mon_e.zn);
                chk("done_locked", LOCKED, mon_e.lk);
                chk("done_err", ERR, mon_e.er);
            end
        end
    end

    // Issues one request in the current (DONE or idle) cycle and traces S through it
    task automatic req(input logic [1:0] idx, input logic off, input int nb, input int nm,
                       input logic [3:0] es, input logic [1:0] ez, input logic el);
        exp_t e;
        REQ_VLD = 1'b1;
        REQ_IDX = idx;
        REQ_OFF = off;
        chk("req_rdy", REQ_RDY, 1);
        @(posedge CP);
        #1;
        e.s = es; e.zn = ez; e.lk = el; e.er = 1'b0; e.cyc = cyc + nb + nm;
        sb.push_back(e);
        REQ_VLD = (nb + nm) > 0;
        REQ_IDX = 2'($urandom_range(0, 3));
        REQ_OFF = 1'($urandom_range(0, 1));
        for (int k = 0; k < nb + nm; k++) begin
            @(negedge CP);
            chk("s_trace", S, (k < nb) ? 4'b0000 : es);
            REQ_IDX = 2'($urandom_range(0, 3));
            REQ_OFF = 1'($urandom_range(0, 1));
        end
        @(negedge CP);
        REQ_VLD = 1'b0;
        #1;
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run3(input logic [1:0] idx, input int lat, input logic [2:0] es, input logic ee);
        int n;
        VLD3 = 1'b1;
        IDX3 = idx;
        OFF3 = 1'b0;
        @(posedge CP);
        #1;
        VLD3 = 1'b0;
        n = 0;
        do begin
            @(negedge CP);
            n++;
        end while (!DONE3 && n < 12);
        chk("dut3_latency", n - 1, lat);
        chk("dut3_s", S3, es);
        chk("dut3_err", ERR3, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CP);
        chk("rst_s", S, 4'b0000);
        chk("rst_zn", ZN, 2'b11);
        chk("rst_done", DONE, 0);
        chk("rst_rdy", REQ_RDY, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_err", ERR, 0);
        RST = 1'b0;
        RST3 = 1'b0;
        #1;
        chk("idle_rdy", REQ_RDY, 1);
        chk("idle_zn", ZN, 2'b11);
        chk("idle_locked", LOCKED, 0);
        chk("idle_err", ERR, 0);

        req(2'd2, 1'b0, 0, 3, 4'b0100, 2'b01, 1'b1);
        req(2'd0, 1'b0, 2, 3, 4'b0001, 2'b11, 1'b1);
        req(2'd1, 1'b0, 2, 3, 4'b0010, 2'b00, 1'b1);
        req(2'd1, 1'b0, 0, 0, 4'b0010, 2'b00, 1'b1);
        req(2'd3, 1'b1, 2, 0, 4'b0000, 2'b11, 1'b0);
        req(2'd2, 1'b1, 0, 0, 4'b0000, 2'b11, 1'b0);
        req(2'd3, 1'b0, 0, 3, 4'b1000, 2'b10, 1'b1);

        REQ_VLD = 1'b1;
        REQ_IDX = 2'd1;
        REQ_OFF = 1'b0;
        @(posedge CP);
        #1;
        REQ_VLD = 1'b0;
        repeat (4) @(negedge CP);
        chk("abort_make_s", S, 4'b0010);
        RST = 1'b1;
        @(negedge CP);
        chk("abort_s", S, 4'b0000);
        chk("abort_done", DONE, 0);
        chk("abort_rdy", REQ_RDY, 0);
        chk("abort_zn", ZN, 2'b11);
        RST = 1'b0;
        #1;
        chk("abort_rdy_after", REQ_RDY, 1);
        repeat (6) @(negedge CP);
        chk("abort_s_settled", S, 4'b0000);

        #1;
        chk("dut3_err_init", ERR3, 0);
        run3(2'd1, 3, 3'b010, 1'b0);
        run3(2'd3, 2, 3'b000, 1'b1);
        run3(2'd0, 3, 3'b001, 1'b1);
        chk("dut3_zn", ZN3, 2'b00);
        run3(2'd3, 2, 3'b000, 1'b1);
        run3(2'd3, 0, 3'b000, 1'b1);
        RST3 = 1'b1;
        @(negedge CP);
        chk("dut3_err_cleared", ERR3, 0);
        RST3 = 1'b0;
        @(negedge CP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
